// File: rtl/lockin_quadrature_accumulator.sv
// Lock-in quadrature accumulator: multiplies zero-mean samples by internal sin/cos tables
// and integrates over M_CYCLES reference periods, emitting one I/Q pair per window.
module lockin_quadrature_accumulator #(
    parameter int Q_in     = 32,
    parameter int N        = 16,
    parameter int M_CYCLES = 8,
    parameter int Q_ref    = 16,
    localparam int Q_out   = Q_in + Q_ref + $clog2(N * M_CYCLES)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [Q_in-1:0]  data_in,
    input  logic                    data_in_valid,
    input  logic                    phase_sync,
    output logic signed [Q_out-1:0] out_i,
    output logic signed [Q_out-1:0] out_q,
    output logic                    data_out_valid
);

    localparam int KW  = $clog2(N);
    localparam int PCW = (M_CYCLES > 1) ? $clog2(M_CYCLES) : 1;
    localparam int PW  = Q_in + Q_ref;

    // Round half away from zero: offset by 0.5 toward the sign, then truncate toward zero.
    function automatic logic signed [Q_ref-1:0] ref_entry(input int idx, input bit use_cos);
        real amp;
        real ang;
        real v;
        amp = real'((64'sd1 <<< (Q_ref - 1)) - 64'sd1);
        ang = 2.0 * 3.141592653589793 * real'(idx) / real'(N);
        v   = amp * (use_cos ? $cos(ang) : $sin(ang));
        v   = (v >= 0.0) ? v + 0.5 : v - 0.5;
        return Q_ref'($rtoi(v));
    endfunction

    logic signed [Q_ref-1:0] sin_rom [N];
    logic signed [Q_ref-1:0] cos_rom [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam logic signed [Q_ref-1:0] SIN_V = ref_entry(g, 1'b0);
        localparam logic signed [Q_ref-1:0] COS_V = ref_entry(g, 1'b1);
        assign sin_rom[g] = SIN_V;
        assign cos_rom[g] = COS_V;
    end

    logic [KW-1:0]  k;
    logic [PCW-1:0] p;
    logic [KW-1:0]  k_use;
    logic [PCW-1:0] p_use;
    logic           k_wrap;
    logic           p_wrap;
    logic           sync_in;

    always_comb begin
        sync_in = data_in_valid && phase_sync;
        k_use   = phase_sync ? '0 : k;
        p_use   = phase_sync ? '0 : p;
        k_wrap  = (k_use == KW'(N - 1));
        p_wrap  = (p_use == PCW'(M_CYCLES - 1));
    end

    logic signed [Q_in-1:0]  d1;
    logic signed [Q_ref-1:0] s1;
    logic signed [Q_ref-1:0] c1;
    logic                    last1;
    logic                    v1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k     <= '0;
            p     <= '0;
            d1    <= '0;
            s1    <= '0;
            c1    <= '0;
            last1 <= 1'b0;
            v1    <= 1'b0;
        end else begin
            v1 <= data_in_valid;
            if (data_in_valid) begin
                d1    <= data_in;
                s1    <= sin_rom[k_use];
                c1    <= cos_rom[k_use];
                last1 <= k_wrap && p_wrap;
                k     <= k_wrap ? '0 : k_use + KW'(1);
                if (k_wrap) begin
                    p <= p_wrap ? '0 : p_use + PCW'(1);
                end else begin
                    p <= p_use;
                end
            end
        end
    end

    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] prod_c;
    logic                 last2;
    logic                 v2;

    // A sync kills the old-window sample moving into the product stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prod_s <= '0;
            prod_c <= '0;
            last2  <= 1'b0;
            v2     <= 1'b0;
        end else begin
            v2 <= v1 && !sync_in;
            if (v1) begin
                prod_s <= PW'(d1) * PW'(s1);
                prod_c <= PW'(d1) * PW'(c1);
                last2  <= last1;
            end
        end
    end

    logic signed [Q_out-1:0] acc_s;
    logic signed [Q_out-1:0] acc_c;
    logic signed [Q_out-1:0] sum_i;
    logic signed [Q_out-1:0] sum_q;
    logic                    sum_v;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_s <= '0;
            acc_c <= '0;
            sum_i <= '0;
            sum_q <= '0;
            sum_v <= 1'b0;
        end else begin
            sum_v <= v2 && last2 && !sync_in;
            if (sync_in) begin
                acc_s <= '0;
                acc_c <= '0;
            end else if (v2) begin
                if (last2) begin
                    sum_i <= acc_s + Q_out'(prod_s);
                    sum_q <= acc_c + Q_out'(prod_c);
                    acc_s <= '0;
                    acc_c <= '0;
                end else begin
                    acc_s <= acc_s + Q_out'(prod_s);
                    acc_c <= acc_c + Q_out'(prod_c);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_i          <= '0;
            out_q          <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= sum_v;
            if (sum_v) begin
                out_i <= sum_i;
                out_q <= sum_q;
            end
        end
    end

endmodule

// File: tb/tb_lockin_quadrature_accumulator.sv
// Directed bench for lockin_quadrature_accumulator: a small N=4/M=2 instance for
// functional cases and a default-parameter instance for the full-scale constant case.
module tb_lockin_quadrature_accumulator;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic signed [31:0] din_a = '0;
    logic               vin_a = 1'b0;
    logic               sync_a = 1'b0;
    logic signed [50:0] oi_a;
    logic signed [50:0] oq_a;
    logic               dov_a;

    logic signed [31:0] din_b = '0;
    logic               vin_b = 1'b0;
    logic               sync_b = 1'b0;
    logic signed [54:0] oi_b;
    logic signed [54:0] oq_b;
    logic               dov_b;

    lockin_quadrature_accumulator #(
        .Q_in(32), .N(4), .M_CYCLES(2), .Q_ref(16)
    ) dut_a (
        .clock(clock), .reset(reset), .data_in(din_a), .data_in_valid(vin_a),
        .phase_sync(sync_a), .out_i(oi_a), .out_q(oq_a), .data_out_valid(dov_a)
    );

    lockin_quadrature_accumulator dut_b (
        .clock(clock), .reset(reset), .data_in(din_b), .data_in_valid(vin_b),
        .phase_sync(sync_b), .out_i(oi_b), .out_q(oq_b), .data_out_valid(dov_b)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    longint pi_a[$];
    longint pq_a[$];
    int     pe_a[$];
    longint pi_b[$];
    longint pq_b[$];
    int     pe_b[$];

    always @(negedge clock) begin
        if (dov_a) begin
            pi_a.push_back(oi_a);
            pq_a.push_back(oq_a);
            pe_a.push_back(cyc);
        end
        if (dov_b) begin
            pi_b.push_back(oi_b);
            pq_b.push_back(oq_b);
            pe_b.push_back(cyc);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int last_acc_a = 0;
    int last_acc_b = 0;

    localparam longint FULL = 131068000;
    longint sine_seq [4] = '{0, 1000, 0, -1000};
    longint cos_seq  [4] = '{1000, 0, -1000, 0};

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic send_a(input longint d, input bit sync, input bit valid);
        @(negedge clock);
        din_a  = 32'(d);
        sync_a = sync;
        vin_a  = valid;
        if (valid) last_acc_a = cyc + 1;
    endtask

    task automatic send_b(input longint d, input bit sync);
        @(negedge clock);
        din_b  = 32'(d);
        sync_b = sync;
        vin_b  = 1'b1;
        last_acc_b = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            vin_a = 1'b0; sync_a = 1'b0;
            vin_b = 1'b0; sync_b = 1'b0;
        end
    endtask

    task automatic clr();
        pi_a.delete(); pq_a.delete(); pe_a.delete();
        pi_b.delete(); pq_b.delete(); pe_b.delete();
    endtask

    task automatic check_win_a(input string tag, input longint ei, input longint eq);
        chk({tag, " pulses"}, pe_a.size(), 1);
        chk({tag, " out_i"}, (pi_a.size() > 0) ? pi_a[0] : -1, ei);
        chk({tag, " out_q"}, (pq_a.size() > 0) ? pq_a[0] : -1, eq);
        chk({tag, " latency"}, (pe_a.size() > 0) ? pe_a[0] - last_acc_a : -1, 3);
        chk({tag, " hold"}, oi_a, ei);
    endtask

    function automatic longint rnd(input real x);
        return (x >= 0.0) ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(-x + 0.5));
    endfunction

    longint ssum;
    longint csum;
    real    ang;

    initial begin
        // Reset state for both instances.
        repeat (2) @(negedge clock);
        chk("rst out_i a", oi_a, 0);
        chk("rst out_q a", oq_a, 0);
        chk("rst dov a", dov_a, 0);
        chk("rst out_i b", oi_b, 0);
        chk("rst out_q b", oq_b, 0);
        chk("rst dov b", dov_b, 0);
        reset = 1'b0;

        clr();
        for (int i = 0; i < 8; i++) send_a(100, i == 0, 1'b1);
        idle(8);
        check_win_a("t1 const", 0, 0);

        clr();
        for (int i = 0; i < 8; i++) send_a(sine_seq[i % 4], i == 0, 1'b1);
        idle(8);
        check_win_a("t2 sine", FULL, 0);

        clr();
        for (int i = 0; i < 8; i++) send_a(cos_seq[i % 4], i == 0, 1'b1);
        idle(8);
        check_win_a("t2 cos", 0, FULL);

        // Bubbles carry junk data and a sync that must be ignored.
        clr();
        for (int i = 0; i < 8; i++) begin
            send_a(sine_seq[i % 4], i == 0, 1'b1);
            send_a(777, 1'b1, 1'b0);
        end
        idle(8);
        check_win_a("t3 bubbles", FULL, 0);

        clr();
        for (int i = 0; i < 16; i++) send_a(sine_seq[i % 4], i == 0, 1'b1);
        idle(8);
        chk("t4 cont pulses", pe_a.size(), 2);
        chk("t4 cont out_i0", (pi_a.size() > 0) ? pi_a[0] : -1, FULL);
        chk("t4 cont out_i1", (pi_a.size() > 1) ? pi_a[1] : -1, FULL);
        chk("t4 cont spacing", (pe_a.size() > 1) ? pe_a[1] - pe_a[0] : -1, 8);
        chk("t4 cont latency", (pe_a.size() > 1) ? pe_a[1] - last_acc_a : -1, 3);

        // Three samples, then a resync: the partial window must leave no trace.
        clr();
        for (int i = 0; i < 3; i++) send_a(sine_seq[i], i == 0, 1'b1);
        for (int i = 0; i < 8; i++) send_a(sine_seq[i % 4], i == 0, 1'b1);
        idle(8);
        check_win_a("t4 resync", FULL, 0);

        clr();
        for (int i = 0; i < 5; i++) send_a(sine_seq[i % 4], i == 0, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        din_a = 5000; vin_a = 1'b1; sync_a = 1'b0;
        #1;
        chk("t5 rst out_i", oi_a, 0);
        chk("t5 rst out_q", oq_a, 0);
        chk("t5 rst dov", dov_a, 0);
        repeat (3) @(negedge clock);
        chk("t5 rst held out_i", oi_a, 0);
        chk("t5 rst held dov", dov_a, 0);
        vin_a = 1'b0;
        reset = 1'b0;
        chk("t5 no stray pulse", pe_a.size(), 0);
        for (int i = 0; i < 8; i++) send_a(sine_seq[i % 4], i == 0, 1'b1);
        idle(8);
        check_win_a("t5 after rst", FULL, 0);

        // Full-scale negative constant at default parameters.
        ssum = 0;
        csum = 0;
        for (int kk = 0; kk < 16; kk++) begin
            ang  = 2.0 * 3.141592653589793 * real'(kk) / 16.0;
            ssum += rnd(32767.0 * $sin(ang));
            csum += rnd(32767.0 * $cos(ang));
        end
        clr();
        for (int i = 0; i < 128; i++) send_b(-64'sd2147483648, i == 0);
        idle(8);
        chk("t6 pulses", pe_b.size(), 1);
        chk("t6 out_i", (pi_b.size() > 0) ? pi_b[0] : -1, -64'sd2147483648 * 8 * ssum);
        chk("t6 out_q", (pq_b.size() > 0) ? pq_b[0] : -1, -64'sd2147483648 * 8 * csum);
        chk("t6 latency", (pe_b.size() > 0) ? pe_b[0] - last_acc_b : -1, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lockin_quadrature_accumulator.md
Name: lockin_quadrature_accumulator

Overview:
- Downstream consumer of the mean-removal stage: takes zero-mean signed samples at one sample per reference sample slot.
- Multiplies each sample by internal sine/cosine reference tables (N samples per stimulus period) and integrates over M_CYCLES periods.
- Emits one in-phase/quadrature pair per integration window for SSVEP amplitude/phase estimation.

Parameters:
- Q_in, 32, signed input sample width.
- N, 16, samples per reference period; power of 2, N ≥ 4.
- M_CYCLES, 8, reference periods per integration window; power of 2, M_CYCLES ≥ 1.
- Q_ref, 16, signed reference table width. Amplitude A = 2^(Q_ref-1)-1.
- Q_out (derived localparam), Q_in+Q_ref+log2(N*M_CYCLES), accumulator and output width.

Ports:
- clock, input, 1, single clock; all logic on rising edge.
- reset, input, 1, asynchronous active-high reset.
- data_in, input, Q_in, signed zero-mean sample.
- data_in_valid, input, 1, qualifies data_in; one sample per asserted cycle, no backpressure.
- phase_sync, input, 1, restarts the table index and window. Sampled only when data_in_valid=1.
- out_i, output, Q_out, signed Σ data·sin over the last window.
- out_q, output, Q_out, signed Σ data·cos over the last window.
- data_out_valid, output, 1, one-cycle pulse when out_i/out_q update.

Behaviour:
- Reset is asynchronous and active-high; clock is named "clock", reset is named "reset".
- On reset, all of the following go to 0:
  - out_i, out_q, data_out_valid;
  - both accumulators, table index k, period counter p;
  - all pipeline registers and valid flags.
- Reset asserted mid-window discards the partial window; no data_out_valid is produced for it.
- Tables, fixed at elaboration:
  - sin[k] = round(A·sin(2πk/N)), cos[k] = round(A·cos(2πk/N)), k = 0..N-1.
  - Round half away from zero.
- Pipeline is free-running; each stage carries a valid flag. Cycles with data_in_valid=0 insert bubbles and change no state.
- Stage 1 (accepting cycle):
  - Register data_in, sin[k], cos[k], and a last flag = (k==N-1 && p==M_CYCLES-1).
  - Advance k, wrapping N-1 to 0. On wrap, p increments, wrapping M_CYCLES-1 to 0.
- Stage 2: prod_s = d·sin, prod_c = d·cos, full-precision signed, width Q_in+Q_ref.
- Stage 3:
  - acc_s += sign-extended prod_s; acc_c likewise.
  - If last: out_i = acc_s + prod_s, out_q = acc_c + prod_c, data_out_valid=1, and both accumulators load 0 in the same cycle.
- Latency: data_out_valid rises 3 clock edges after the edge that accepted the final sample of the window. It is high for exactly one cycle; outputs hold until the next window.
- No saturation: Q_out guarantees no overflow for any input and table value.
- phase_sync=1 with data_in_valid=1:
  - The accompanying sample uses index k=0 and becomes the first sample of a new window; p is set to 0 and k continues to 1.
  - The in-flight partial window is dropped: accumulators clear before this sample is added, and no output is produced.
  - Samples of the dropped window still in stages 2–3 are discarded; the valid flag is cleared with the sync.
- phase_sync with data_in_valid=0 has no effect.
- phase_sync on the sample that would be the window's last: sync wins and no output is produced.
- Back-to-back windows: the first sample of the next window may enter stage 3 on the cycle after the clear. No sample is lost and no gap cycles are required.

Test Plan:
Common setup for 1–4: N=4, M_CYCLES=2, Q_ref=16 (A=32767; sin=[0,32767,0,-32767], cos=[32767,0,-32767,0]), phase_sync pulsed with the first sample.
1. Constant data_in=100 for 8 valid cycles -> one data_out_valid pulse 3 cycles after the 8th sample; out_i=0, out_q=0.
2. Sequence [0,1000,0,-1000]×2 -> out_i=131,068,000, out_q=0. Sequence [1000,0,-1000,0]×2 -> out_i=0, out_q=131,068,000.
3. Case 2 sine input with data_in_valid toggled 1/0 every cycle -> identical outputs; pulse timing is 3 edges after the last accepted sample.
4. 16 continuous sine samples, then a phase_sync at sample 3 of a later stream:
   - Continuous run gives two pulses, 8 cycles apart, both out_i=131,068,000.
   - The window interrupted by the sync produces no pulse; the next pulse comes 8 samples after the sync.
5. Reset asserted mid-window (after 5 samples), then 8 fresh sine samples with phase_sync -> all outputs 0 during reset; single pulse with out_i=131,068,000.
6. Defaults (N=16, M_CYCLES=8): data_in=-2^31 constant for 128 samples -> out_i=0, and out_q=0 (within table-rounding residue computed by the model); no overflow.
